// File: rtl/uart_cmd_ctrl.sv
// Frame receive controller: parses SYNC,ADDR,LEN,payload,CHK from uart_rx strobes and
// commits buffered payload to a register bank. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_done,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2 || TIMEOUT_CLKS > 65536) begin : g_param_chk
    $error("uart_cmd_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [7:0] len_q, len_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q [MAX_LEN];
  logic       buf_we, ok_pulse, err_pulse, ovr_set;
  logic [1:0] err_val;

`ifdef UART_CMD_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        tmo_active;
  assign tmo_active = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);

  // Counts silent clocks between bytes; a byte always restarts it.
  always_ff @(posedge clock) begin
    if (reset || !tmo_active || rx_done) tmo_q <= '0;
    else                                 tmo_q <= tmo_q + 16'd1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    buf_we    = 1'b0;
    ok_pulse  = 1'b0;
    err_pulse = 1'b0;
    err_val   = 2'd0;
    ovr_set   = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (rx_done && rx_byte == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR:
        if (rx_done) begin
          base_d  = rx_byte;
          chk_d   = rx_byte;
          state_d = S_LEN;
        end
      S_LEN:
        if (rx_done) begin
          if (rx_byte == 8'd0 || rx_byte > 8'(MAX_LEN)) begin
            err_pulse = 1'b1;
            err_val   = 2'd1;
            state_d   = S_IDLE;
          end else begin
            len_d   = rx_byte;
            chk_d   = chk_q ^ rx_byte;
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end
      S_PAYLOAD:
        if (rx_done) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ rx_byte;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_CHECK;
        end
      S_CHECK:
        if (rx_done) begin
          if (rx_byte == chk_q) begin
            idx_d   = 8'd0;
            state_d = S_COMMIT;
          end else begin
            err_pulse = 1'b1;
            err_val   = 2'd2;
            state_d   = S_IDLE;
          end
        end
      S_COMMIT: begin
        // wr_en is high for the whole of COMMIT, so wr_ready alone means accept.
        ovr_set = rx_done;
        if (wr_ready) begin
          if (idx_q == len_q - 8'd1) begin
            ok_pulse = 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_CMD_TIMEOUT_EN
    if (tmo_active && !rx_done && tmo_q == 16'(TIMEOUT_CLKS - 1)) begin
      err_pulse = 1'b1;
      err_val   = 2'd3;
      state_d   = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
      frame_ok  <= ok_pulse;
      frame_err <= err_pulse;
      busy      <= (state_d != S_IDLE);
      wr_en     <= (state_d == S_COMMIT);
      if (err_pulse) err_code <= err_val;
      if (ovr_set)   overrun  <= 1'b1;
      // Write outputs are registered from next-state values so they present the
      // current beat in the same cycle COMMIT is active.
      if (state_d == S_COMMIT) begin
        wr_addr <= base_d + idx_d;
        wr_data <= buf_q[idx_d[IW-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we) buf_q[idx_q[IW-1:0]] <= rx_byte;
  end

endmodule
